// File: rtl/mul_seq.sv
// Iterative shift-add multiplier for the EX-stage MUL/MLA path.
// Retires BPC multiplier bits per cycle, stalls the pipe while busy, and reports N/Z flags.
module mul_seq #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             accumulate,
  input  logic             set_flags,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic [4:0]       flags_we
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    count_q, count_d;
  logic             s_q, s_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [4:0]       flags_q, flags_d;
  logic [4:0]       flags_we_q, flags_we_d;
  logic [WIDTH-1:0] pp;
  logic             accept;

  assign accept = start & ~flush & ((state_q == IDLE) | (state_q == DONE));
  // Gated by reset so the hold is released immediately when the op is lost.
  assign stall  = reset & ~flush & ((state_q == RUN) | accept);

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign flags    = flags_q;
  assign flags_we = flags_we_q;

  // Partial product of the low BPC multiplier bits, truncated to WIDTH.
  always_comb begin
    pp = '0;
    for (int j = 0; j < BPC; j++)
      if (mplier_q[j]) pp = pp + (mcand_q << j);
  end

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    count_d    = count_q;
    s_d        = s_q;
    result_d   = result_q;
    done_d     = 1'b0;
    flags_d    = 5'b00000;
    flags_we_d = 5'b00000;

    case (state_q)
      RUN: begin
        acc_d    = acc_q + pp;
        mcand_d  = mcand_q << BPC;
        mplier_d = mplier_q >> BPC;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d    = DONE;
          done_d     = 1'b1;
          result_d   = acc_d;
          flags_d    = {acc_d[WIDTH-1], acc_d == '0, 3'b000};
          flags_we_d = s_q ? 5'b11000 : 5'b00000;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d  = RUN;
      mcand_d  = a;
      mplier_d = b;
      acc_d    = accumulate ? c : '0;
      s_d      = set_flags;
      count_d  = CW'(N);
    end

    // Abort wins over everything, including a completion in this same cycle.
    if (flush) begin
      state_d    = IDLE;
      result_d   = result_q;
      done_d     = 1'b0;
      flags_d    = 5'b00000;
      flags_we_d = 5'b00000;
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      s_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      flags_q    <= 5'b00000;
      flags_we_q <= 5'b00000;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      s_q        <= s_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      flags_we_q <= flags_we_d;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_mul_seq;

  logic        clk, reset, start, accumulate, set_flags, flush;
  logic [31:0] a, b, c;
  logic        busy, stall, done;
  logic [31:0] result;
  logic [4:0]  flags, flags_we;
  logic        busy4, stall4, done4;
  logic [31:0] result4;
  logic [4:0]  flags4, flags_we4;

  int checks   = 0;
  int failures = 0;

  mul_seq #(.WIDTH(32), .BPC(1)) dut (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
    .set_flags(set_flags), .flush(flush), .a(a), .b(b), .c(c),
    .busy(busy), .stall(stall), .done(done), .result(result),
    .flags(flags), .flags_we(flags_we)
  );

  mul_seq #(.WIDTH(32), .BPC(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
    .set_flags(set_flags), .flush(flush), .a(a), .b(b), .c(c),
    .busy(busy4), .stall(stall4), .done(done4), .result(result4),
    .flags(flags4), .flags_we(flags_we4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [31:0] model_res(input logic [31:0] x, y, z, input logic acc);
    logic [63:0] p;
    p = {32'b0, x} * {32'b0, y} + (acc ? {32'b0, z} : 64'b0);
    return p[31:0];
  endfunction

  function automatic logic [4:0] model_flags(input logic [31:0] r);
    return {r[31], r == 32'b0, 3'b000};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] xa, xb, xc, input logic xacc, xs);
    a = xa; b = xb; c = xc; accumulate = xacc; set_flags = xs; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Called in the cycle after start; cyc=1 there, returns cycle offset of done.
  task automatic wait_done(output int cyc, output bit to);
    cyc = 1; to = 1'b0;
    while (done !== 1'b1 && !to) begin
      if (cyc >= 100) to = 1'b1;
      else begin tick; cyc++; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1; a = 32'd3; b = 32'd5;
    #3;
    checks++;
    if ({busy, done, stall, result, flags, flags_we} !== 44'b0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b stall=%b result=%h flags=%b we=%b, want all 0",
               busy, done, stall, result, flags, flags_we);
    end
    start = 1'b0;
    tick; tick;
    reset = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    int bad = 0;
    a = 32'd3; b = 32'd5; c = 32'd0; accumulate = 1'b0; set_flags = 1'b0; start = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_start_cycle: stall=%b busy=%b, want 1 0", stall, busy);
    end
    tick;
    start = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      if (busy !== (k <= 32) || stall !== (k <= 32) || done !== (k == 33)) begin
        bad++;
        $display("FAIL basic_timing: T+%0d busy=%b stall=%b done=%b", k, busy, stall, done);
      end
      if (k < 33) tick;
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (result !== 32'd15 || flags_we !== 5'b00000 || flags !== 5'b00000) begin
      failures++;
      $display("FAIL basic_result: result=%h flags=%b we=%b, want 0000000f 00000 00000",
               result, flags, flags_we);
    end
    tick;
    checks++;
    if (done !== 1'b0 || result !== 32'd15) begin
      failures++;
      $display("FAIL basic_after_done: done=%b result=%h, want 0 0000000f", done, result);
    end
  endtask

  task automatic test_flags;
    logic [31:0] ta[3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000};
    logic [31:0] tb[3] = '{32'd2, 32'd1, 32'h0001_0000};
    logic        tacc[3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] er[3] = '{32'h0000_0003, 32'h8000_0000, 32'h0000_0000};
    logic [4:0]  ef[3] = '{5'b00000, 5'b10000, 5'b01000};
    int cyc; bit to;
    for (int i = 0; i < 3; i++) begin
      launch(ta[i], tb[i], 32'd5, tacc[i], 1'b1);
      wait_done(cyc, to);
      checks++;
      if (to || result !== er[i] || flags !== ef[i] || flags_we !== 5'b11000) begin
        failures++;
        $display("FAIL flags_case%0d: to=%b result=%h flags=%b we=%b, want %h %b 11000",
                 i, to, result, flags, flags_we, er[i], ef[i]);
      end
      tick;
      checks++;
      if (flags !== 5'b00000 || flags_we !== 5'b00000) begin
        failures++;
        $display("FAIL flags_zeroed%0d: flags=%b we=%b, want 0 0", i, flags, flags_we);
      end
    end
  endtask

  task automatic test_flush;
    int cyc; bit to; int dn = 0;
    launch(32'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    wait_done(cyc, to);
    tick;
    launch(32'd9, 32'd9, 32'd0, 1'b0, 1'b1);
    for (int k = 1; k < 10; k++) tick;
    flush = 1'b1; start = 1'b1; a = 32'd1; b = 32'd1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall: stall=%b, want 0", stall);
    end
    tick;
    flush = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy: busy at T+11=%b, want 0", busy);
    end
    for (int k = 0; k < 40; k++) begin if (done === 1'b1 || busy === 1'b1) dn++; tick; end
    checks++;
    if (dn != 0 || result !== 32'd15) begin
      failures++;
      $display("FAIL flush_no_done: active cycles=%0d result=%h, want 0 0000000f", dn, result);
    end
    // Flush together with start in IDLE drops the request.
    flush = 1'b1; start = 1'b1; a = 32'd4; b = 32'd4;
    tick;
    flush = 1'b0; start = 1'b0;
    dn = 0;
    for (int k = 0; k < 40; k++) begin if (done === 1'b1 || busy === 1'b1) dn++; tick; end
    checks++;
    if (dn != 0 || result !== 32'd15) begin
      failures++;
      $display("FAIL flush_drops_start: active cycles=%0d result=%h, want 0 0000000f", dn, result);
    end
  endtask

  task automatic test_ignore_start;
    int k; int dn = 0;
    launch(32'd100, 32'd7, 32'd0, 1'b0, 1'b0);
    for (k = 1; k < 5; k++) tick;
    a = 32'd1; b = 32'd1; start = 1'b1;
    tick;
    start = 1'b0;
    k = 6;
    while (done !== 1'b1 && k < 100) begin tick; k++; end
    checks++;
    if (k != 33 || result !== 32'd700) begin
      failures++;
      $display("FAIL ignore_start: done at T+%0d result=%h, want T+33 000002bc", k, result);
    end
    tick;
    for (int j = 0; j < 40; j++) begin if (done === 1'b1 || busy === 1'b1) dn++; tick; end
    checks++;
    if (dn != 0) begin
      failures++;
      $display("FAIL ignore_start_queued: active cycles=%0d, want 0", dn);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; bit to;
    launch(32'd7, 32'd6, 32'd0, 1'b0, 1'b0);
    wait_done(cyc, to);
    checks++;
    if (to || cyc != 33 || result !== 32'd42 || stall !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: to=%b cyc=%0d result=%h stall=%b, want 33 0000002a 0",
               to, cyc, result, stall);
    end
    launch(32'd2, 32'd9, 32'd0, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(cyc, to);
    checks++;
    if (to || cyc != 33 || result !== 32'd18) begin
      failures++;
      $display("FAIL b2b_second: to=%b cyc=%0d result=%h, want 33 00000012", to, cyc, result);
    end
    tick;
  endtask

  task automatic test_random;
    logic [31:0] x, y, z, er; logic xacc, xs; int cyc; bit to; int bad = 0;
    for (int i = 0; i < 24; i++) begin
      x = $urandom; y = $urandom; z = $urandom;
      case ($urandom_range(0, 4))
        0: x = 32'hFFFF_FFFF;
        1: y = 32'h8000_0000;
        2: y = 32'd0;
        3: begin x = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF; end
        default: ;
      endcase
      xacc = 1'($urandom_range(0, 1));
      xs   = 1'($urandom_range(0, 1));
      er = model_res(x, y, z, xacc);
      launch(x, y, z, xacc, xs);
      wait_done(cyc, to);
      checks++;
      if (to || cyc != 33 || result !== er || flags !== model_flags(er) ||
          flags_we !== (xs ? 5'b11000 : 5'b00000)) begin
        failures++; bad++;
        $display("FAIL random%0d: a=%h b=%h c=%h acc=%b s=%b cyc=%0d result=%h flags=%b we=%b, want %h %b",
                 i, x, y, z, xacc, xs, cyc, result, flags, flags_we, er, model_flags(er));
      end
      if ($urandom_range(0, 1) == 1) tick;
      tick;
    end
  endtask

  task automatic test_bpc4;
    logic [31:0] x, y, z, er; logic xacc; int k; int cyc; bit to;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin x = 32'h1234_5678; y = 32'h9ABC_DEF0; z = 32'd0; xacc = 1'b0; end
      else begin x = $urandom; y = $urandom; z = $urandom; xacc = 1'($urandom_range(0, 1)); end
      er = model_res(x, y, z, xacc);
      launch(x, y, z, xacc, 1'b1);
      k = 1;
      while (done4 !== 1'b1 && k < 50) begin tick; k++; end
      checks++;
      if (k != 9 || result4 !== er || (i == 0 && result4 !== 32'h242D_2080) ||
          flags4 !== model_flags(er) || flags_we4 !== 5'b11000) begin
        failures++;
        $display("FAIL bpc4_op%0d: done at T+%0d result=%h flags=%b we=%b, want T+9 %h %b 11000",
                 i, k, result4, flags4, flags_we4, er, model_flags(er));
      end
      wait_done(cyc, to);
      tick;
    end
  endtask

  task automatic test_reset_midrun;
    int dn = 0;
    launch(32'd3, 32'd5, 32'd0, 1'b0, 1'b1);
    for (int k = 1; k < 20; k++) tick;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || stall !== 1'b0 ||
        flags !== 5'b00000 || flags_we !== 5'b00000) begin
      failures++;
      $display("FAIL reset_midrun: busy=%b done=%b result=%h stall=%b, want 0 0 0 0",
               busy, done, result, stall);
    end
    tick;
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin if (done === 1'b1 || busy === 1'b1) dn++; tick; end
    checks++;
    if (dn != 0) begin
      failures++;
      $display("FAIL reset_midrun_idle: active cycles after release=%0d, want 0", dn);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; accumulate = 1'b0; set_flags = 1'b0; flush = 1'b0;
    a = '0; b = '0; c = '0;
    test_reset;
    test_basic;
    test_flags;
    test_flush;
    test_ignore_start;
    test_back_to_back;
    test_random;
    test_bpc4;
    test_reset_midrun;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
Multi-cycle sequencer for the EX-stage multiply path. It replaces the single-cycle MUL/MLA result (a*b, a*b+c) with an iterative shift-add engine of BPC multiplier bits per cycle. It raises a pipeline stall while busy and returns the WIDTH-bit result plus N/Z flag updates in the same {N,Z,C,V,Q} order used by the ALU flag bus.

Parameters:
WIDTH, 32, operand/result width.
BPC, 1, multiplier bits retired per cycle; legal values are 1, 2 and 4, and BPC must divide WIDTH. N = WIDTH/BPC iterations.

Ports:
clk  in  1  single clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request pulse from decode/EX.
accumulate  in  1  1 = MLA (a*b+c), 0 = MUL (a*b); sampled with start.
set_flags  in  1  S bit; sampled with start.
flush  in  1  synchronous abort of the in-flight operation.
a  in  WIDTH  multiplicand; sampled with start.
b  in  WIDTH  multiplier; sampled with start.
c  in  WIDTH  accumulate addend; sampled with start.
busy  out  1  registered; high while state is RUN.
stall  out  1  combinational pipeline hold.
done  out  1  registered one-cycle result-valid pulse.
result  out  WIDTH  registered product; holds until next done.
flags  out  5  {N,Z,C,V,Q}; valid with done.
flags_we  out  5  per-flag write enable; valid with done.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy, done, result, flags, flags_we, count and all internal registers are 0; stall=0 while reset is low.
- States: IDLE, RUN, DONE.
- Accept condition: start=1, state is IDLE or DONE, flush=0. On accept, register mcand=a, mplier=b, acc = accumulate ? c : 0, s_q=set_flags, count=N; next state is RUN.
- start is ignored in RUN; no queueing.
- RUN, each cycle:
  - acc += mplier[BPC-1:0] * mcand, truncated mod 2^WIDTH.
  - mcand <<= BPC; mplier >>= BPC (logical); count -= 1.
  - When count==1 this cycle, next state is DONE.
- DONE, one cycle:
  - done=1; result=acc.
  - flags = {acc[WIDTH-1], acc==0, 0, 0, 0}.
  - flags_we = s_q ? 5'b11000 : 5'b00000. C, V and Q are never written.
  - Next state is RUN if start is accepted this cycle, otherwise IDLE.
- result, flags and flags_we are registered on DONE entry, so done, result and flags are coincident. flags and flags_we are zeroed in cycles where done=0; result holds its value.
- Latency: start at cycle T gives busy for T+1..T+N and done at T+N+1 (T+33 for the defaults).
- Throughput: one op per N+1 cycles when start is issued in the DONE cycle.
- stall = (state==RUN) | accept. stall is low in the DONE cycle, so the pipeline advances and captures result.
- flush=1 (any state): next state is IDLE; busy and done are 0 next cycle; result and flags keep their prior values; a start in the same cycle is dropped; stall=0 in a flush cycle.
- Arithmetic: result equals (a*b + (accumulate?c:0)) mod 2^WIDTH for signed and unsigned interpretations alike. There are no early-termination shortcuts, so latency is fixed.
- Reset asserted mid-RUN: operation lost, all outputs return to reset values immediately. After release, state is IDLE.

Test Plan:
- MUL a=3, b=5, set_flags=0, start at T -> stall high T..T+32, busy T+1..T+32, done only at T+33, result=15, flags_we=5'b00000.
- MLA a=0xFFFFFFFF, b=2, c=5, set_flags=1 -> result=0x00000003, flags=5'b00000, flags_we=5'b11000.
- MUL a=0x80000000, b=1, S=1 -> result=0x80000000, flags=5'b10000. Then MUL a=0x00010000, b=0x00010000, S=1 -> result=0, flags=5'b01000.
- Mid-op events, first op a=3, b=5:
  - start pulses at T+5 are ignored.
  - flush at T+10 -> busy=0 at T+11, no done pulse, result stays 15 from the prior op.
- Back-to-back, first op a=7, b=6, second op a=2, b=9:
  - second start in the DONE cycle of the first -> first done result=42.
  - second done exactly 33 cycles later with result=18; stall low in the first DONE cycle.
- Reset:
  - reset low at T+20 of a running op -> busy, done, result and stall are 0 without a clock edge.
  - BPC=4 build, a=0x12345678, b=0x9ABCDEF0 -> done at T+9, result=0x242D2080.
